// File: rtl/sr_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sr_alu_seq
//  Purpose  : Sequential ALU with a valid/ready request side and a
//             valid/ready result side. Simple ops finish in one edge.
//             Shifts step one bit per cycle. MULU uses shift-add and
//             DIVU/REMU use restoring division, one bit per cycle each.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             in_valid   request strobe; accepted together with in_ready
//             in_ready   high only while idle
//             srcA/srcB  operands, sampled on accept
//             oper       4-bit opcode, sampled on accept
//             out_valid  result available (held until out_ready)
//             out_ready  consumer accepts the result
//             result     registered result
//             zero       registered, high when result is all zeros
//  Revision : 1.0  initial release
// ============================================================================
module sr_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [3:0]       oper,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] c_OP_ADD  = 4'd0;
   localparam logic [3:0] c_OP_OR   = 4'd1;
   localparam logic [3:0] c_OP_SRL  = 4'd2;
   localparam logic [3:0] c_OP_SLTU = 4'd3;
   localparam logic [3:0] c_OP_SUB  = 4'd4;
   localparam logic [3:0] c_OP_AND  = 4'd5;
   localparam logic [3:0] c_OP_SLL  = 4'd6;
   localparam logic [3:0] c_OP_SRA  = 4'd7;
   localparam logic [3:0] c_OP_MULU = 4'd8;
   localparam logic [3:0] c_OP_DIVU = 4'd9;
   localparam logic [3:0] c_OP_REMU = 4'd10;

   localparam logic [SHW:0] c_ITER_FULL = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] c_CNT_ONE   = (SHW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;      // shift operand / multiplicand / dividend->quotient
   logic [WIDTH-1:0] r_b;      // multiplier / divisor
   logic [WIDTH-1:0] r_acc;    // product accumulator / partial remainder
   logic [SHW:0]     r_cnt;    // remaining iterations; one bit wider so WIDTH fits
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   state_t           w_state_nxt;
   logic [3:0]       w_op_nxt;
   logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_result_nxt;
   logic [SHW:0]     w_cnt_nxt;
   logic             w_zero_nxt;

   logic [SHW-1:0]   w_shamt;
   logic             w_is_shift, w_is_div, w_iterative;
   logic [WIDTH-1:0] w_single_res;

   logic [WIDTH:0]   w_div_rem_sh;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_step_a, w_step_b, w_step_acc, w_step_res;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign zero      = r_zero;

   // ------------------------------------------------------------------
   // Request decode: which ops need the iterative datapath
   // ------------------------------------------------------------------
   assign w_shamt     = srcB[SHW-1:0];
   assign w_is_shift  = (oper == c_OP_SRL) || (oper == c_OP_SLL) || (oper == c_OP_SRA);
   assign w_is_div    = (oper == c_OP_DIVU) || (oper == c_OP_REMU);
   // Zero shift amounts and division by zero have a fixed answer, so they
   // complete in one edge instead of entering RUN.
   assign w_iterative = (w_is_shift && (w_shamt != '0)) ||
                        (oper == c_OP_MULU) ||
                        (w_is_div && (srcB != '0));

   always_comb begin
      w_single_res = srcA + srcB;
      case (oper)
         c_OP_OR   : w_single_res = srcA | srcB;
         c_OP_SLTU : w_single_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         c_OP_SUB  : w_single_res = srcA - srcB;
         c_OP_AND  : w_single_res = srcA & srcB;
         c_OP_SRL,
         c_OP_SLL,
         c_OP_SRA  : w_single_res = srcA;          // shift by zero
         c_OP_DIVU : w_single_res = '1;            // divide by zero
         c_OP_REMU : w_single_res = srcA;          // remainder by zero
         default   : w_single_res = srcA + srcB;   // ADD and opcodes 11-15
      endcase
   end

   // ------------------------------------------------------------------
   // One iteration of the multi-cycle datapath
   // ------------------------------------------------------------------
   // Restoring division: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The quotient bits are
   // shifted into r_a as the dividend bits leave it.
   assign w_div_rem_sh = {r_acc, r_a[WIDTH-1]};
   assign w_div_diff   = w_div_rem_sh - {1'b0, r_b};
   assign w_div_ge     = ~w_div_diff[WIDTH];

   always_comb begin
      w_step_a   = r_a;
      w_step_b   = r_b;
      w_step_acc = r_acc;
      w_step_res = r_result;
      case (r_op)
         c_OP_SRL : begin
            w_step_a   = {1'b0, r_a[WIDTH-1:1]};
            w_step_res = w_step_a;
         end
         c_OP_SLL : begin
            w_step_a   = {r_a[WIDTH-2:0], 1'b0};
            w_step_res = w_step_a;
         end
         c_OP_SRA : begin
            // The MSB never changes during SRA, so it still holds the
            // original sign bit on every step.
            w_step_a   = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            w_step_res = w_step_a;
         end
         c_OP_MULU : begin
            w_step_acc = r_b[0] ? (r_acc + r_a) : r_acc;
            w_step_a   = {r_a[WIDTH-2:0], 1'b0};
            w_step_b   = {1'b0, r_b[WIDTH-1:1]};
            w_step_res = w_step_acc;
         end
         c_OP_DIVU,
         c_OP_REMU : begin
            w_step_acc = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem_sh[WIDTH-1:0];
            w_step_a   = {r_a[WIDTH-2:0], w_div_ge};
            w_step_res = (r_op == c_OP_DIVU) ? w_step_a : w_step_acc;
         end
         default : begin
            w_step_res = r_result;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state and register-next logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_result_nxt = r_result;
      w_zero_nxt   = r_zero;
      case (r_state)
         S_IDLE : begin
            if (in_valid) begin
               w_op_nxt = oper;
               if (w_iterative) begin
                  w_a_nxt     = srcA;
                  w_b_nxt     = srcB;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = w_is_shift ? {1'b0, w_shamt} : c_ITER_FULL;
                  w_state_nxt = S_RUN;
               end else begin
                  w_result_nxt = w_single_res;
                  w_zero_nxt   = (w_single_res == '0);
                  w_state_nxt  = S_DONE;
               end
            end
         end
         S_RUN : begin
            w_a_nxt   = w_step_a;
            w_b_nxt   = w_step_b;
            w_acc_nxt = w_step_acc;
            w_cnt_nxt = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
               w_result_nxt = w_step_res;
               w_zero_nxt   = (w_step_res == '0);
               w_state_nxt  = S_DONE;
            end
         end
         S_DONE : begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default : begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_op     <= w_op_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_result <= w_result_nxt;
         r_zero   <= w_zero_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_alu_seq
//  Purpose  : Self-checking bench for sr_alu_seq at WIDTH=8 and WIDTH=32.
//             Both instances share common stimulus; sel picks the one that
//             receives in_valid and whose outputs are observed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sr_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;            // 0: 8-bit instance, 1: 32-bit instance
   logic        d_in_valid;
   logic        d_out_ready;
   logic [63:0] d_srcA, d_srcB;
   logic [3:0]  d_oper;

   logic        iv8, iv32;
   logic        ir8, ir32, ov8, ov32, z8, z32;
   logic [7:0]  res8;
   logic [31:0] res32;

   logic        m_in_ready, m_out_valid, m_zero;
   logic [63:0] m_result;

   int n_tests = 0;
   int n_fail  = 0;

   assign iv8  = d_in_valid & ~sel;
   assign iv32 = d_in_valid &  sel;

   assign m_in_ready  = sel ? ir32 : ir8;
   assign m_out_valid = sel ? ov32 : ov8;
   assign m_zero      = sel ? z32  : z8;
   assign m_result    = sel ? {32'd0, res32} : {56'd0, res8};

   sr_alu_seq #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .srcA      (d_srcA[7:0]),
      .srcB      (d_srcB[7:0]),
      .oper      (d_oper),
      .out_valid (ov8),
      .out_ready (d_out_ready),
      .result    (res8),
      .zero      (z8)
   );

   sr_alu_seq #(.WIDTH(32)) u_dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv32),
      .in_ready  (ir32),
      .srcA      (d_srcA[31:0]),
      .srcB      (d_srcB[31:0]),
      .oper      (d_oper),
      .out_valid (ov32),
      .out_ready (d_out_ready),
      .result    (res32),
      .zero      (z32)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result straight from the opcode table, using plain operators.
   function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                         input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask, a, b, r, sext;
      int sh;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a    = a_in & mask;
      b    = b_in & mask;
      sh   = int'(b % 64'(w));
      sext = a[w-1] ? (a | ~mask) : a;
      case (op)
         4'd1    : r = a | b;
         4'd2    : r = a >> sh;
         4'd3    : r = (a < b) ? 64'd1 : 64'd0;
         4'd4    : r = a - b;
         4'd5    : r = a & b;
         4'd6    : r = a << sh;
         4'd7    : r = 64'($signed(sext) >>> sh);
         4'd8    : r = a * b;
         4'd9    : r = (b == 0) ? mask : a / b;
         4'd10   : r = (b == 0) ? a : a % b;
         default : r = a + b;
      endcase
      return r & mask;
   endfunction

   // Edges from accept to out_valid, counting the accept edge as 1.
   function automatic int model_lat(input int w, input logic [3:0] op, input logic [63:0] b_in);
      logic [63:0] b;
      int sh;
      b  = (w == 64) ? b_in : (b_in & ((64'd1 << w) - 64'd1));
      sh = int'(b % 64'(w));
      case (op)
         4'd2, 4'd6, 4'd7 : return (sh == 0) ? 1 : sh + 1;
         4'd8             : return w + 1;
         4'd9, 4'd10      : return (b == 0) ? 1 : w + 1;
         default          : return 1;
      endcase
   endfunction

   task automatic run_op(input logic s, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input int hold);
      int          w, el, lat;
      logic [63:0] er;
      string       t;
      w  = s ? 32 : 8;
      er = model(w, op, a, b);
      el = model_lat(w, op, b);
      t  = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a, b);

      @(negedge clk);
      sel         = s;
      d_oper      = op;
      d_srcA      = a;
      d_srcB      = b;
      d_in_valid  = 1'b1;
      d_out_ready = (hold == 0);
      #1;
      chk({t, " in_ready before accept"}, 64'(m_in_ready), 64'd1);

      @(posedge clk);
      #1;
      // Scramble the inputs after accept; they must not reach the result.
      d_in_valid = 1'b0;
      d_srcA     = {$urandom, $urandom};
      d_srcB     = {$urandom, $urandom};
      d_oper     = 4'($urandom);
      lat = 1;
      while (!m_out_valid && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!m_out_valid) begin
         chk({t, " out_valid timeout"}, 64'(m_out_valid), 64'd1);
      end
      chk({t, " latency"}, 64'(lat), 64'(el));
      chk({t, " result"}, m_result, er);
      chk({t, " zero"}, 64'(m_zero), 64'(er == 0));

      for (int i = 0; i < hold; i++) begin
         d_in_valid = 1'b1;
         d_oper     = 4'($urandom);
         d_srcA     = {$urandom, $urandom};
         @(posedge clk);
         #1;
         chk({t, " hold out_valid"}, 64'(m_out_valid), 64'd1);
         chk({t, " hold in_ready"}, 64'(m_in_ready), 64'd0);
         chk({t, " hold result"}, m_result, er);
         chk({t, " hold zero"}, 64'(m_zero), 64'(er == 0));
      end

      d_in_valid  = 1'b0;
      d_out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({t, " in_ready after drain"}, 64'(m_in_ready), 64'd1);
      chk({t, " out_valid after drain"}, 64'(m_out_valid), 64'd0);
      d_out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        seen;
      logic [3:0]  op;
      logic [63:0] a, b;

      rst         = 1'b1;
      sel         = 1'b0;
      d_in_valid  = 1'b0;
      d_out_ready = 1'b0;
      d_srcA      = '0;
      d_srcB      = '0;
      d_oper      = '0;

      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk($sformatf("reset sel%0d out_valid", s), 64'(m_out_valid), 64'd0);
         chk($sformatf("reset sel%0d result", s), m_result, 64'd0);
         chk($sformatf("reset sel%0d zero", s), 64'(m_zero), 64'd1);
         chk($sformatf("reset sel%0d in_ready", s), 64'(m_in_ready), 64'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready after reset release", 64'(ir8 & ir32), 64'd1);

      // Directed cases on the 32-bit instance
      run_op(1'b1, 4'd0,  64'hFFFF_FFFF, 64'd1, 0);            // ADD wrap -> 0
      run_op(1'b1, 4'd7,  64'h8000_0000, 64'd4, 0);            // SRA -> F800_0000, lat 5
      run_op(1'b1, 4'd6,  64'h1234_5678, 64'd0, 0);            // SLL by 0
      run_op(1'b1, 4'd8,  64'h0001_0001, 64'h0001_0001, 0);    // MULU -> 0002_0001
      run_op(1'b1, 4'd9,  64'd100, 64'd7, 0);                  // DIVU -> 14
      run_op(1'b1, 4'd10, 64'd100, 64'd7, 0);                  // REMU -> 2
      run_op(1'b1, 4'd9,  64'd5, 64'd0, 0);                    // DIVU /0 -> all ones
      run_op(1'b1, 4'd10, 64'd5, 64'd0, 0);                    // REMU /0 -> 5
      run_op(1'b1, 4'd3,  64'hFFFF_FFFF, 64'd1, 0);            // SLTU unsigned -> 0
      run_op(1'b1, 4'd5,  64'hF0F0_1234, 64'h0F0F_4321, 10);   // held result
      run_op(1'b0, 4'd8,  64'hFF, 64'hFF, 0);                  // 8-bit MULU -> 01

      // Reset in the middle of a division
      @(negedge clk);
      sel        = 1'b1;
      d_oper     = 4'd9;
      d_srcA     = 64'hFFFF_FFFF;
      d_srcB     = 64'd3;
      d_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d_in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("div running before reset", 64'(m_out_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("abort out_valid", 64'(m_out_valid), 64'd0);
      chk("abort result", m_result, 64'd0);
      chk("abort zero", 64'(m_zero), 64'd1);
      chk("abort in_ready", 64'(m_in_ready), 64'd1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         seen = seen | m_out_valid;
      end
      chk("no out_valid after abort", 64'(seen), 64'd0);
      run_op(1'b1, 4'd4, 64'd3, 64'd5, 0);                     // SUB -> FFFF_FFFE

      // Randomized operations on both widths
      for (int s = 0; s < 2; s++) begin
         for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0       : b = 64'd0;
               1       : b = 64'($urandom_range(0, 9));
               default : b = {$urandom, $urandom};
            endcase
            run_op(s[0], op, a, b, int'($urandom_range(0, 2)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sr_alu_seq.md
SR_ALU_SEQ -- requirements
Module: sr_alu_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have derived localparam SHW = $clog2(WIDTH), meaning the shift-amount width.
REQ-003 Port clk  input  1  rising-edge clock; the only clock.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port in_valid  input  1  operation request.
REQ-006 Port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 Port srcA  input  WIDTH  operand A, sampled on accept.
REQ-008 Port srcB  input  WIDTH  operand B, sampled on accept.
REQ-009 Port oper  input  4  opcode, sampled on accept.
REQ-010 Port out_valid  output  1  result available.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port result  output  WIDTH  registered result.
REQ-013 Port zero  output  1  registered; high when result is all zeros.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 OR, 2 SRL, 3 SLTU, 4 SUB, 5 AND, 6 SLL, 7 SRA, 8 MULU (low WIDTH bits of the unsigned product), 9 DIVU, 10 REMU; opcodes 11-15 SHALL behave as ADD.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be high only in IDLE.
REQ-016 Transitions SHALL be:
- IDLE -> DONE: accept of a single-cycle op.
- IDLE -> RUN: accept of an iterative op.
- RUN -> DONE: when the iteration counter expires.
- DONE -> IDLE: when out_ready is high.
REQ-017 out_valid SHALL equal (state == DONE); result and zero SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 Single-cycle ops SHALL raise out_valid on the edge after accept, giving a latency of 1: ADD, OR, SLTU, SUB, AND, DIVU/REMU with srcB == 0, and shifts with srcB[SHW-1:0] == 0.
REQ-019 Shift ops SHALL shift by exactly one bit per RUN cycle, using shift amount srcB[SHW-1:0]; latency SHALL be shamt+1 edges from accept to out_valid.
- SRA SHALL replicate the original bit WIDTH-1 on each step.
REQ-020 MULU SHALL use shift-add, one bit per cycle, with a latency of WIDTH+1 edges.
REQ-021 DIVU/REMU SHALL use restoring division, one quotient bit per cycle, with a latency of WIDTH+1 edges.
REQ-022 Division by zero SHALL give: DIVU result all ones; REMU result srcA.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; SUB borrow and ADD carry SHALL be discarded, and SLTU SHALL compare unsigned.
REQ-024 Inputs SHALL be ignored while in_ready is low; operand changes during RUN SHALL NOT affect the result.
REQ-025 In DONE with out_ready high, the block SHALL return to IDLE; a new accept is possible only on the following edge, so peak throughput is one op per 2 cycles.
REQ-026 The iteration counter SHALL be SHW+1 bits wide so that WIDTH iterations count without wrap-around.

Reset
REQ-027 On rst assertion, asynchronously: state SHALL be IDLE, out_valid 0, result 0, zero 1, counter 0, and internal operand/accumulator registers 0.
REQ-028 rst asserted during RUN or DONE SHALL abort the operation; no out_valid pulse SHALL follow reset release.
REQ-029 in_ready SHALL go high on the first edge after rst deasserts.

Verification
REQ-030 Scenario: WIDTH=32, ADD srcA=32'hFFFF_FFFF, srcB=1, out_ready=1 -> 1 cycle later out_valid=1, result=0, zero=1.
REQ-031 Scenario: SRA srcA=32'h8000_0000, srcB=4 -> out_valid exactly 5 edges after accept, result=32'hF800_0000.
- SLL with srcB=0 -> 1-cycle latency, result=srcA.
REQ-032 Scenario: MULU 32'h0001_0001 x 32'h0001_0001 -> 33 edges, result=32'h0002_0001.
- DIVU 100/7 -> 14.
- REMU 100/7 -> 2.
- DIVU 5/0 -> 32'hFFFF_FFFF, 1-cycle latency.
- REMU 5/0 -> 5, 1-cycle latency.
REQ-033 Scenario: out_ready held low for 10 cycles after DONE -> result, zero and out_valid stable, in_ready=0, and a new in_valid is not accepted; after out_ready=1, in_ready=1 on the next edge.
REQ-034 Scenario: rst pulsed at RUN cycle 10 of a DIVU -> state IDLE, out_valid=0, result=0; a subsequent SUB 3-5 -> 32'hFFFF_FFFE.
REQ-035 Scenario: randomized ops across WIDTH=8 and WIDTH=32 -> result and latency match a reference model for every op, including opcodes 11-15 treated as ADD.
